// File: rtl/vmem_arbiter_if.sv
// Display-read, pixel-write and frame-memory port signals of the video memory arbiter.
// slave = arbiter side, master = the surrounding clients and memory.
interface vmem_arbiter_if #(
    parameter int ADDR_W     = 19,
    parameter int DATA_W     = 24,
    parameter int FIFO_DEPTH = 4
);
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

    logic              disp_req;
    logic [ADDR_W-1:0] disp_addr;
    logic              disp_valid;
    logic [DATA_W-1:0] disp_data;

    logic              wr_valid;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ready;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic [LVL_W-1:0]  fifo_level;
    logic [15:0]       underrun_cnt;

    modport slave (
        input  disp_req, disp_addr, wr_valid, wr_addr, wr_data, mem_rdata,
        output disp_valid, disp_data, wr_ready, mem_en, mem_we, mem_addr, mem_wdata,
               fifo_level, underrun_cnt
    );

    modport master (
        output disp_req, disp_addr, wr_valid, wr_addr, wr_data, mem_rdata,
        input  disp_valid, disp_data, wr_ready, mem_en, mem_we, mem_addr, mem_wdata,
               fifo_level, underrun_cnt
    );
endinterface

// File: rtl/vmem_arbiter.sv
// Generic FIFO: level-counted storage with wrapping pointers.
// Latency: pushed entry visible at the head the cycle after the push.
// Backpressure: caller pushes only when ~full and pops only when ~empty.
module sync_fifo #(
    parameter  int W     = 8,
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int LVL_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [W-1:0]     push_dat,
    input  logic             pop,
    output logic [W-1:0]     head_dat,
    output logic             full,
    output logic             empty,
    output logic [LVL_W-1:0] level
);
    logic [W-1:0]     store [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) store[wr_ptr] <= push_dat;
    end

    assign head_dat = store[rd_ptr];
    assign full     = (level == LVL_W'(DEPTH));
    assign empty    = (level == '0);
endmodule

// Frame memory arbiter: display reads first, buffered pixel writes in idle slots.
// Latency: display pixel 1 cycle after disp_req; queued write issues when a slot frees.
// Backpressure: wr_ready drops while the write FIFO is full; display is never stalled.
module vmem_arbiter #(
    parameter int ADDR_W     = 19,
    parameter int DATA_W     = 24,
    parameter int FIFO_DEPTH = 4,
    parameter int STARVE_MAX = 64
) (
    input logic           clk,
    input logic           rst,
    vmem_arbiter_if.slave bus
);
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
    localparam int CNT_W = $clog2(STARVE_MAX + 1);

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_req_t;

    typedef enum logic [1:0] {GNT_IDLE, GNT_READ, GNT_WRITE} gnt_e;

    wr_req_t           push_req;
    wr_req_t           head_req;
    logic              full;
    logic              empty;
    logic [LVL_W-1:0]  fifo_level;
    logic              push;
    logic              pop;
    logic              force_wr;
    logic              preempt;
    gnt_e              gnt;

    logic [CNT_W-1:0]  starve_cnt;
    logic              disp_valid_q;
    logic              rd_q;
    logic [DATA_W-1:0] held_pix;
    logic [15:0]       underrun_q;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;

    assign bus.wr_ready = ~full & ~rst;
    assign push         = bus.wr_valid & ~full & ~rst;
    assign push_req     = '{addr: bus.wr_addr, data: bus.wr_data};

    sync_fifo #(.W($bits(wr_req_t)), .DEPTH(FIFO_DEPTH)) u_wr_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_dat (push_req),
        .pop      (pop),
        .head_dat (head_req),
        .full     (full),
        .empty    (empty),
        .level    (fifo_level)
    );

    // A starved write beats the display; the display then replays its held pixel.
    assign force_wr = (starve_cnt == CNT_W'(STARVE_MAX)) & ~empty;

    always_comb begin
        gnt = GNT_IDLE;
        if (rst)               gnt = GNT_IDLE;
        else if (force_wr)     gnt = GNT_WRITE;
        else if (bus.disp_req) gnt = GNT_READ;
        else if (~empty)       gnt = GNT_WRITE;
    end

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (gnt)
            GNT_READ: begin
                mem_en   = 1'b1;
                mem_addr = bus.disp_addr;
            end
            GNT_WRITE: begin
                mem_en    = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = head_req.addr;
                mem_wdata = head_req.data;
            end
            default: ;
        endcase
    end

    assign pop     = (gnt == GNT_WRITE);
    assign preempt = force_wr & bus.disp_req & ~rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt   <= '0;
            disp_valid_q <= 1'b0;
            rd_q         <= 1'b0;
            held_pix     <= '0;
            underrun_q   <= '0;
        end else begin
            if (pop || empty)
                starve_cnt <= '0;
            else if (starve_cnt != CNT_W'(STARVE_MAX))
                starve_cnt <= starve_cnt + 1'b1;

            disp_valid_q <= bus.disp_req;
            rd_q         <= (gnt == GNT_READ);
            if (rd_q) held_pix <= bus.mem_rdata;
            if (preempt && underrun_q != 16'hFFFF) underrun_q <= underrun_q + 1'b1;
        end
    end

    // Read data arrives straight from memory; otherwise the last good pixel is replayed.
    assign bus.disp_valid   = disp_valid_q;
    assign bus.disp_data    = rd_q ? bus.mem_rdata : held_pix;
    assign bus.underrun_cnt = underrun_q;
    assign bus.fifo_level   = fifo_level;
    assign bus.mem_en       = mem_en;
    assign bus.mem_we       = mem_we;
    assign bus.mem_addr     = mem_addr;
    assign bus.mem_wdata    = mem_wdata;
endmodule

// File: tb/tb_vmem_arbiter.sv
// Bench for vmem_arbiter: vector table, starvation, full-FIFO and mid-run reset sequences.
module tb_vmem_arbiter;
    localparam int ADDR_W     = 19;
    localparam int DATA_W     = 24;
    localparam int FIFO_DEPTH = 4;
    localparam int STARVE_MAX = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    vmem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) bus ();

    vmem_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH), .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Frame memory model: one-cycle read latency, junk on the read bus when not reading.
    logic [23:0] mem_model [int];
    always @(posedge clk) begin
        if (bus.mem_en && !bus.mem_we)
            bus.mem_rdata <= mem_model.exists(int'(bus.mem_addr)) ? mem_model[int'(bus.mem_addr)] : 24'h0;
        else
            bus.mem_rdata <= 24'hBADBAD;
    end
    always @(posedge clk) begin
        if (bus.mem_en && bus.mem_we) mem_model[int'(bus.mem_addr)] = bus.mem_wdata;
    end

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [18:0] addr;
        logic [23:0] data;
    } wreq_t;
    wreq_t exp_q[$];

    typedef struct {
        logic        dreq;
        logic [18:0] daddr;
        logic        wv;
        logic [18:0] waddr;
        logic [23:0] wdata;
        logic        en;
        logic        we;
        logic [18:0] maddr;
        logic [23:0] mwdata;
        logic        rdy;
        logic [2:0]  lvl;
        logic        dv;
        logic [23:0] dd;
    } vec_t;
    vec_t vt[15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Write scoreboard: accepted pushes queue up, every memory write must match the oldest.
    task automatic score();
        wreq_t e;
        if (bus.mem_en && bus.mem_we) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_write", {13'h0, bus.mem_addr}, 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                chk("sb_wr_addr", {13'h0, bus.mem_addr}, {13'h0, e.addr});
                chk("sb_wr_data", {8'h0, bus.mem_wdata}, {8'h0, e.data});
            end
        end
        if (bus.wr_valid && bus.wr_ready) exp_q.push_back('{addr: bus.wr_addr, data: bus.wr_data});
    endtask

    task automatic drive(input logic dreq, input logic [18:0] daddr,
                         input logic wv, input logic [18:0] waddr, input logic [23:0] wdata);
        @(negedge clk);
        bus.disp_req  = dreq;
        bus.disp_addr = daddr;
        bus.wr_valid  = wv;
        bus.wr_addr   = waddr;
        bus.wr_data   = wdata;
        #1;
        score();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int k;
        int n;
        bus.disp_req  = 1'b0;
        bus.disp_addr = '0;
        bus.wr_valid  = 1'b0;
        bus.wr_addr   = '0;
        bus.wr_data   = '0;
        mem_model[5] = 24'h123456;
        mem_model[7] = 24'hABCDEF;

        vt = '{
            //  dreq daddr    wv  waddr    wdata        en  we  maddr    mwdata       rdy lvl dv  dd
            '{1'b0, 19'h0, 1'b0, 19'h0,   24'h0,      1'b0,1'b0,19'h0,   24'h0,      1'b1,3'd0,1'b0,24'h0},
            '{1'b0, 19'h0, 1'b1, 19'h10,  24'hFF0000, 1'b0,1'b0,19'h0,   24'h0,      1'b1,3'd0,1'b0,24'h0},
            '{1'b0, 19'h0, 1'b0, 19'h0,   24'h0,      1'b1,1'b1,19'h10,  24'hFF0000, 1'b1,3'd1,1'b0,24'h0},
            '{1'b1, 19'h5, 1'b0, 19'h0,   24'h0,      1'b1,1'b0,19'h5,   24'h0,      1'b1,3'd0,1'b0,24'h0},
            '{1'b0, 19'h0, 1'b0, 19'h0,   24'h0,      1'b0,1'b0,19'h0,   24'h0,      1'b1,3'd0,1'b1,24'h123456},
            '{1'b0, 19'h0, 1'b0, 19'h0,   24'h0,      1'b0,1'b0,19'h0,   24'h0,      1'b1,3'd0,1'b0,24'h123456},
            '{1'b1, 19'h7, 1'b1, 19'h100, 24'h000A00, 1'b1,1'b0,19'h7,   24'h0,      1'b1,3'd0,1'b0,24'h123456},
            '{1'b1, 19'h7, 1'b1, 19'h101, 24'h000A01, 1'b1,1'b0,19'h7,   24'h0,      1'b1,3'd1,1'b1,24'hABCDEF},
            '{1'b1, 19'h7, 1'b1, 19'h102, 24'h000A02, 1'b1,1'b0,19'h7,   24'h0,      1'b1,3'd2,1'b1,24'hABCDEF},
            '{1'b0, 19'h0, 1'b0, 19'h0,   24'h0,      1'b1,1'b1,19'h100, 24'h000A00, 1'b1,3'd3,1'b1,24'hABCDEF},
            '{1'b1, 19'h5, 1'b0, 19'h0,   24'h0,      1'b1,1'b0,19'h5,   24'h0,      1'b1,3'd2,1'b0,24'hABCDEF},
            '{1'b0, 19'h0, 1'b0, 19'h0,   24'h0,      1'b1,1'b1,19'h101, 24'h000A01, 1'b1,3'd2,1'b1,24'h123456},
            '{1'b1, 19'h7, 1'b0, 19'h0,   24'h0,      1'b1,1'b0,19'h7,   24'h0,      1'b1,3'd1,1'b0,24'h123456},
            '{1'b0, 19'h0, 1'b0, 19'h0,   24'h0,      1'b1,1'b1,19'h102, 24'h000A02, 1'b1,3'd1,1'b1,24'hABCDEF},
            '{1'b0, 19'h0, 1'b0, 19'h0,   24'h0,      1'b0,1'b0,19'h0,   24'h0,      1'b1,3'd0,1'b0,24'hABCDEF}
        };

        // Reset state while rst is held
        @(negedge clk);
        #1;
        chk("rst_mem_en",   {31'h0, bus.mem_en}, 32'h0);
        chk("rst_mem_we",   {31'h0, bus.mem_we}, 32'h0);
        chk("rst_wr_ready", {31'h0, bus.wr_ready}, 32'h0);
        chk("rst_level",    {29'h0, bus.fifo_level}, 32'h0);
        chk("rst_dvalid",   {31'h0, bus.disp_valid}, 32'h0);
        chk("rst_ddata",    {8'h0, bus.disp_data}, 32'h0);
        chk("rst_underrun", {16'h0, bus.underrun_cnt}, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Single write, display read/hold, alternating drain
        for (int i = 0; i < 15; i++) begin
            drive(vt[i].dreq, vt[i].daddr, vt[i].wv, vt[i].waddr, vt[i].wdata);
            chk($sformatf("v%0d_mem_en", i),   {31'h0, bus.mem_en}, {31'h0, vt[i].en});
            chk($sformatf("v%0d_mem_we", i),   {31'h0, bus.mem_we}, {31'h0, vt[i].we});
            chk($sformatf("v%0d_mem_addr", i), {13'h0, bus.mem_addr}, {13'h0, vt[i].maddr});
            chk($sformatf("v%0d_mem_wdata", i),{8'h0, bus.mem_wdata}, {8'h0, vt[i].mwdata});
            chk($sformatf("v%0d_wr_ready", i), {31'h0, bus.wr_ready}, {31'h0, vt[i].rdy});
            chk($sformatf("v%0d_level", i),    {29'h0, bus.fifo_level}, {29'h0, vt[i].lvl});
            chk($sformatf("v%0d_dvalid", i),   {31'h0, bus.disp_valid}, {31'h0, vt[i].dv});
            chk($sformatf("v%0d_ddata", i),    {8'h0, bus.disp_data}, {8'h0, vt[i].dd});
        end
        chk("alt_underrun", {16'h0, bus.underrun_cnt}, 32'h0);

        // Starvation: display hogs the port, each queued write forced after 64 idle cycles
        for (k = 0; k <= 262; k++) begin
            drive(1'b1, 19'h5, (k < 4), 19'(32'h300 + k), 24'(32'hC000 + k));
            chk($sformatf("starve_we_%0d", k), {31'h0, bus.mem_we},
                {31'h0, (k == 65 || k == 130 || k == 195 || k == 260)});
            if (k == 3) chk("starve_4th_ready", {31'h0, bus.wr_ready}, 32'h1);
            if (k == 4) begin
                chk("starve_full_level", {29'h0, bus.fifo_level}, 32'd4);
                chk("starve_full_ready", {31'h0, bus.wr_ready}, 32'h0);
            end
            if (k == 66 || k == 131 || k == 196 || k == 261) begin
                n = (k - 1) / 65;
                chk($sformatf("starve_dvalid_%0d", k), {31'h0, bus.disp_valid}, 32'h1);
                chk($sformatf("starve_held_%0d", k), {8'h0, bus.disp_data}, 32'h123456);
                chk($sformatf("starve_underrun_%0d", k), {16'h0, bus.underrun_cnt}, n);
            end
        end
        chk("starve_drained", {29'h0, bus.fifo_level}, 32'h0);

        // Full FIFO with a pop in the same cycle: write refused, taken next cycle
        for (int i = 0; i < 4; i++) drive(1'b1, 19'h5, 1'b1, 19'(32'h200 + i), 24'(32'hD00 + i));
        drive(1'b0, 19'h0, 1'b1, 19'h204, 24'hD04);
        chk("full_pop_ready", {31'h0, bus.wr_ready}, 32'h0);
        chk("full_pop_we",    {31'h0, bus.mem_we}, 32'h1);
        chk("full_pop_level", {29'h0, bus.fifo_level}, 32'd4);
        drive(1'b1, 19'h5, 1'b1, 19'h204, 24'hD04);
        chk("after_pop_level", {29'h0, bus.fifo_level}, 32'd3);
        chk("after_pop_ready", {31'h0, bus.wr_ready}, 32'h1);
        drive(1'b1, 19'h5, 1'b0, 19'h0, 24'h0);
        chk("refill_level", {29'h0, bus.fifo_level}, 32'd4);
        for (int i = 0; i < 20 && bus.fifo_level != 0; i++) drive(1'b0, 19'h0, 1'b0, 19'h0, 24'h0);
        chk("full_drain_level", {29'h0, bus.fifo_level}, 32'h0);

        // Reset mid-operation with queued writes and a display read in flight
        for (int i = 0; i < 3; i++) drive(1'b1, 19'h7, 1'b1, 19'(32'h400 + i), 24'(32'hE00 + i));
        @(negedge clk);
        bus.wr_valid = 1'b0;
        bus.disp_req = 1'b1;
        rst = 1'b1;
        #1;
        exp_q.delete();
        chk("mid_rst_mem_en",   {31'h0, bus.mem_en}, 32'h0);
        chk("mid_rst_wr_ready", {31'h0, bus.wr_ready}, 32'h0);
        chk("mid_rst_level",    {29'h0, bus.fifo_level}, 32'h0);
        chk("mid_rst_dvalid",   {31'h0, bus.disp_valid}, 32'h0);
        chk("mid_rst_underrun", {16'h0, bus.underrun_cnt}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        bus.disp_req = 1'b0;
        #1;
        chk("post_rst_dvalid", {31'h0, bus.disp_valid}, 32'h0);
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 19'h0, 1'b0, 19'h0, 24'h0);
            chk($sformatf("post_rst_idle_%0d", i), {31'h0, bus.mem_en}, 32'h0);
        end

        chk("sb_leftover", exp_q.size(), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/vmem_arbiter.md
Name: vmem_arbiter

Overview:
Shares the single-port video frame memory between the VGA scan-out path and a pixel writer, such as a keyboard- or UART-driven drawing engine. Display reads have priority and a fixed one-cycle latency. Writes are buffered in a small FIFO and drained in idle slots. A starvation guard forces writes through when they have waited too long, and counts the display underruns this causes.

Parameters:
ADDR_W, 19, frame memory address width ({h_addr[9:0], v_addr[8:0]})
DATA_W, 24, pixel width (RGB888)
FIFO_DEPTH, 4, write FIFO entries; power of two, >= 2
STARVE_MAX, 64, consecutive cycles a non-empty FIFO may go without a grant before a write is forced

Ports:
clk  input  1  system clock
rst  input  1  asynchronous reset, active-high
disp_req  input  1  display read request, this cycle
disp_addr  input  ADDR_W  display read address
disp_valid  output  1  display pixel valid; one cycle after disp_req
disp_data  output  DATA_W  display pixel
wr_valid  input  1  writer request valid
wr_addr  input  ADDR_W  write address
wr_data  input  DATA_W  write pixel
wr_ready  output  1  FIFO can accept a write
mem_en  output  1  memory port enable
mem_we  output  1  memory write enable (1 = write, 0 = read)
mem_addr  output  ADDR_W  memory address
mem_wdata  output  DATA_W  memory write data
mem_rdata  input  DATA_W  memory read data; valid the cycle after a read with mem_en=1
fifo_level  output  clog2(FIFO_DEPTH)+1  current FIFO occupancy
underrun_cnt  output  16  count of display reads replaced by a held pixel; saturating

Behaviour:
- Reset is asynchronous and active-high. While rst=1 and after its release:
  - FIFO empty, fifo_level=0
  - starvation counter 0, underrun_cnt 0
  - disp_valid=0, disp_data=0, held pixel=0
  - mem_en=0, mem_we=0, wr_ready=0
- wr_ready = ~full & ~rst. It is combinational and independent of any pop in the same cycle: a full FIFO deasserts wr_ready even if a pop happens that cycle.
- Push occurs when wr_valid & wr_ready. Order is strictly FIFO.
- Arbitration each cycle (combinational mem_* outputs):
  - force = (starve_cnt == STARVE_MAX) & ~empty.
  - If force: write the FIFO head (mem_en=1, mem_we=1), pop it.
  - Else if disp_req: read disp_addr (mem_en=1, mem_we=0).
  - Else if ~empty: write the FIFO head and pop it.
  - Else: mem_en=0.
  - mem_addr and mem_wdata are don't-care when mem_en=0; drive 0.
- Starvation counter:
  - Cleared on any write grant or when the FIFO is empty.
  - Otherwise increments, saturating at STARVE_MAX.
- Display path: fixed latency of 1 cycle. disp_valid(N+1) = disp_req(N), whether or not the read was granted.
  - Granted read at N: disp_data(N+1) = mem_rdata; the held pixel register updates to that value.
  - Preempted at N (forced write): disp_data(N+1) = held pixel; underrun_cnt increments and saturates at 16'hFFFF.
  - disp_valid=0: disp_data holds its previous value.
- No forwarding: a display read of an address still pending in the FIFO returns the old memory contents.
- Push and pop in the same cycle (non-full): fifo_level is unchanged.
- Pointers are log2(FIFO_DEPTH) bits wide and wrap modulo FIFO_DEPTH. Full/empty are derived from the level counter.
- Reset asserted mid-operation: pending FIFO writes are discarded, and any in-flight display response is dropped (disp_valid=0 next cycle).

Test Plan:
1. Reset release, idle, then wr_valid=1, addr=0x00010, data=0xFF0000 -> wr_ready=1; next cycle mem_en=1, mem_we=1, mem_addr=0x00010, mem_wdata=0xFF0000; fifo_level returns to 0.
2. disp_req held high continuously, push 4 writes -> 4th push accepted and wr_ready=0 with fifo_level=4. No write is granted for 64 cycles, then exactly one forced write occurs. At the next cycle disp_valid=1, disp_data equals the previous pixel, underrun_cnt=1. Pattern repeats every 65 cycles until the FIFO is empty.
3. Memory preloaded with mem[0x00005]=0x123456, disp_req=1 with addr=0x00005 for one cycle -> next cycle disp_valid=1, disp_data=0x123456; the following cycle disp_valid=0 and disp_data still 0x123456.
4. Full FIFO with wr_valid=1 in a cycle where a pop occurs -> write is not accepted (wr_ready=0); fifo_level becomes 3, and the write is accepted on the next cycle.
5. Alternating disp_req (1,0,1,0) with 3 queued writes -> writes are granted only in cycles with disp_req=0, the FIFO drains in 6 cycles, and underrun_cnt stays 0.
6. Assert rst with fifo_level=3 and disp_req pending -> immediately mem_en=0, wr_ready=0, fifo_level=0; the cycle after release disp_valid=0 and no stale writes are issued.
